// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle for the BCD up/down counter.
// The master drives the count controls; the slave (the counter) returns the count and flags.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 2
);
    localparam int W = 4 * DIGITS;

    logic         enable;
    logic         up_down;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] limit;
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;
    logic         load_err;

    modport master (
        output enable, up_down, load, load_val, limit,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  enable, up_down, load, load_val, limit,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with a programmable wrap limit and validated parallel load.
// tc is combinational and flags that the next enabled edge wraps, for chaining higher decades.
module bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input logic                  clock_i,
    input logic                  reset_i,
    bcd_updown_counter_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]      count_q, count_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;
    logic [W-1:0]      lim_eff, inc_val, dec_val;
    logic [DIGITS-1:0] lim_bad, ld_bad, low_nine, low_zero;
    logic              load_ok, at_top, at_zero;

    // Per-decade carry/borrow chain: a digit moves only when every lower digit is 9 (up) or 0 (down).
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] d;
        assign d          = count_q[4*k +: 4];
        assign lim_bad[k] = bus.limit[4*k +: 4] > 4'd9;
        assign ld_bad[k]  = bus.load_val[4*k +: 4] > 4'd9;

        if (k == 0) begin : g_lsd
            assign low_nine[k] = 1'b1;
            assign low_zero[k] = 1'b1;
        end else begin : g_upper
            assign low_nine[k] = low_nine[k-1] & (count_q[4*(k-1) +: 4] == 4'd9);
            assign low_zero[k] = low_zero[k-1] & (count_q[4*(k-1) +: 4] == 4'd0);
        end

        assign inc_val[4*k +: 4] = !low_nine[k] ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
        assign dec_val[4*k +: 4] = !low_zero[k] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
    end

    // With every nibble in 0..9 a plain binary compare orders BCD values correctly.
    assign lim_eff = (|lim_bad) ? {DIGITS{4'h9}} : bus.limit;
    assign load_ok = ~(|ld_bad) && (bus.load_val <= lim_eff);
    assign at_top  = count_q >= lim_eff;
    assign at_zero = count_q == '0;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.load) begin
            if (load_ok) count_d = bus.load_val;
            else         err_d   = 1'b1;
        end else if (bus.enable) begin
            if (bus.up_down) begin
                count_d = at_top ? '0 : inc_val;
                wrap_d  = at_top;
            end else begin
                count_d = at_zero ? lim_eff : dec_val;
                wrap_d  = at_zero;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = err_q;
    assign bus.tc       = bus.enable & ((bus.up_down & at_top) | (~bus.up_down & at_zero));
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for the two-decade BCD counter: full sweeps, limits, loads, reset priority.
module tb_bcd_updown_counter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bcd_updown_counter_if #(.DIGITS(2)) bus ();
    bcd_updown_counter #(.DIGITS(2)) dut (.clock_i(clk), .reset_i(rst), .bus(bus));

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic ud, input logic ld, input logic [7:0] lv);
        bus.enable   = en;
        bus.up_down  = ud;
        bus.load     = ld;
        bus.load_val = lv;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] c, input logic w, input logic e);
        chk({tag, ".count"}, bus.count, c);
        chk({tag, ".wrap"}, {7'd0, bus.wrap}, {7'd0, w});
        chk({tag, ".load_err"}, {7'd0, bus.load_err}, {7'd0, e});
    endtask

    initial begin
        int e;
        rst = 1'b1;
        bus.limit = 8'h99;
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        chk_state("reset", 8'h00, 1'b0, 1'b0);

        // Full 0..99 up sweep
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        e = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            chk("sweep99.tc", {7'd0, bus.tc}, {7'd0, e == 99});
            tick();
            chk("sweep99.wrap", {7'd0, bus.wrap}, {7'd0, e == 99});
            e = (e == 99) ? 0 : e + 1;
            chk("sweep99.count", bus.count, bcd2(e));
        end

        // Limit 23: two complete cycles
        bus.limit = 8'h23;
        for (int i = 0; i < 48; i++) begin
            #1;
            chk("sweep23.tc", {7'd0, bus.tc}, {7'd0, e == 23});
            tick();
            chk("sweep23.wrap", {7'd0, bus.wrap}, {7'd0, e == 23});
            e = (e == 23) ? 0 : e + 1;
            chk("sweep23.count", bus.count, bcd2(e));
        end
        chk("sweep23.end", bus.count, 8'h00);

        // Down from zero wraps to the limit
        bus.up_down = 1'b0;
        #1;
        chk("down0.tc", {7'd0, bus.tc}, 8'h01);
        tick(); chk_state("down0.wrap", 8'h23, 1'b1, 1'b0);
        tick(); chk_state("down0.22", 8'h22, 1'b0, 1'b0);
        tick(); chk_state("down0.21", 8'h21, 1'b0, 1'b0);

        // Decade borrow and 00 -> 99 wrap
        bus.limit = 8'h99;
        drive(1'b0, 1'b0, 1'b1, 8'h40); tick(); chk_state("ld40", 8'h40, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00); tick(); chk_state("dn39", 8'h39, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h00); tick(); chk_state("ld00", 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00); tick(); chk_state("dn99", 8'h99, 1'b1, 1'b0);

        // Load validation with limit 50
        bus.limit = 8'h50;
        drive(1'b0, 1'b1, 1'b1, 8'h37); tick(); chk_state("ld37", 8'h37, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h3A); tick(); chk_state("ld3A", 8'h37, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h00); tick(); chk_state("errclr", 8'h37, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h60); tick(); chk_state("ld60", 8'h37, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 8'h12); tick(); chk_state("ldwins", 8'h12, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h55); tick(); chk_state("ldbad_nostep", 8'h12, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 8'h50); tick(); chk_state("ld_eq_lim", 8'h50, 1'b0, 1'b0);

        // Limit lowered below the count
        bus.limit = 8'h99;
        drive(1'b0, 1'b1, 1'b1, 8'h45); tick(); chk_state("ld45a", 8'h45, 1'b0, 1'b0);
        bus.limit = 8'h20;
        drive(1'b0, 1'b1, 1'b0, 8'h00); tick(); chk_state("hold_noclamp", 8'h45, 1'b0, 1'b0);
        bus.enable = 1'b1;
        #1; chk("low.tc", {7'd0, bus.tc}, 8'h01);
        tick(); chk_state("low.up_wrap", 8'h00, 1'b1, 1'b0);
        bus.limit = 8'h99;
        drive(1'b0, 1'b1, 1'b1, 8'h45); tick(); chk_state("ld45b", 8'h45, 1'b0, 1'b0);
        bus.limit = 8'h20;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        #1; chk("low.dn_tc", {7'd0, bus.tc}, 8'h00);
        tick(); chk_state("low.dn44", 8'h44, 1'b0, 1'b0);

        // Non-BCD limit nibble acts as 99
        bus.limit = 8'hF5;
        drive(1'b0, 1'b1, 1'b1, 8'h98); tick(); chk_state("f5.ld98", 8'h98, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'h00); tick(); chk_state("f5.up99", 8'h99, 1'b0, 1'b0);
        #1; chk("f5.tc", {7'd0, bus.tc}, 8'h01);
        tick(); chk_state("f5.wrap", 8'h00, 1'b1, 1'b0);

        // Reset beats load and enable
        bus.limit = 8'h99;
        drive(1'b0, 1'b1, 1'b1, 8'h57); tick(); chk_state("ld57", 8'h57, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'h33); tick(); chk_state("rst_prio", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        tick(); chk_state("resume01", 8'h01, 1'b0, 1'b0);
        tick(); chk_state("resume02", 8'h02, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
